// File: rtl/reg_share_pkg.sv
// Shared types and default sizing for the register-sharing arbiter.
package reg_share_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// searching upward with wrap.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [PW-1:0]   o_idx
);

  logic w_found;
  int   w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = PW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared register.
// Optional even-parity output q_par when REG_SHARE_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | no transaction; arbitrate any pending request from r_ptr
// GRANT   | gnt held one-hot; capture if the winner still requests, else abort
// CAPTURE | q loaded, ack high for this cycle; advance r_ptr past the winner
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [WIDTH-1:0]      q,
  output logic [PW-1:0]         owner
`ifdef REG_SHARE_PARITY_EN
  ,
  output logic                  q_par
`endif
);

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic [PW-1:0]     r_gidx, w_gidx_nxt;
  logic              r_ack, w_ack_nxt;
  logic [WIDTH-1:0]  r_q, w_q_nxt;
  logic [PW-1:0]     r_owner, w_owner_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic              w_load;
  logic [NREQ-1:0]   w_pick_oh;
  logic [PW-1:0]     w_pick_idx;
  logic [WIDTH-1:0]  w_slice;
  logic [PW-1:0]     w_gidx_inc;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  // Only the latched winner's slice is ever looked at, so other requesters
  // can change freely while a transaction is in flight.
  assign w_slice    = wdata[int'(r_gidx)*WIDTH +: WIDTH];
  assign w_gidx_inc = (r_gidx == PW'(NREQ-1)) ? '0 : r_gidx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gidx_nxt  = r_gidx;
    w_ack_nxt   = 1'b0;
    w_q_nxt     = r_q;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick_oh;
          w_gidx_nxt  = w_pick_idx;
        end
      end
      GRANT: begin
        if (req[r_gidx]) begin
          w_state_nxt = CAPTURE;
          w_load      = 1'b1;
          w_q_nxt     = w_slice;
          w_owner_nxt = r_gidx;
          w_ack_nxt   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        end
      end
      CAPTURE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_ptr_nxt   = w_gidx_inc;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
    // A capture on the same edge takes precedence over clear.
    if (clr && !w_load) w_q_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_ack   <= 1'b0;
      r_q     <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ack   <= w_ack_nxt;
      r_q     <= w_q_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign ack   = r_ack;
  assign q     = r_q;
  assign owner = r_owner;

`ifdef REG_SHARE_PARITY_EN
  logic r_q_par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q_par <= 1'b0;
    else       r_q_par <= ^w_q_nxt;
  end

  assign q_par = r_q_par;
`endif

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the register (2..8).
REQ-002 Parameter WIDTH, default 8: width of the shared D register.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester write request, level, held until ack.
REQ-006 wdata  input  NREQ*WIDTH  packed write data; slice i = wdata[i*WIDTH +: WIDTH].
REQ-007 clr  input  1  synchronous clear request for the shared register.
REQ-008 gnt  output  NREQ  registered one-hot grant, zero when no grant.
REQ-009 ack  output  1  one-cycle pulse: the granted write was captured.
REQ-010 q  output  WIDTH  shared register contents.
REQ-011 owner  output  clog2(NREQ)  index of the last requester written; 0 after reset.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT, CAPTURE.
REQ-013 IDLE: if any req bit is high, select a requester round-robin starting at ptr, set gnt one-hot and go to GRANT; otherwise stay.
REQ-014 GRANT: if req[g] is still high, go to CAPTURE, load q from slice g, set owner = g and pulse ack; if req[g] is low, abort to IDLE, clear gnt, leave q and ptr unchanged.
REQ-015 CAPTURE: clear gnt and ack, set ptr = (g+1) mod NREQ and return to IDLE unconditionally.
REQ-016 Latency: a req sampled in IDLE at edge k SHALL give gnt after edge k, and q/ack after edge k+1; the maximum rate is one write per 3 cycles.
REQ-017 Round-robin: the requester just served SHALL have the lowest priority at the next arbitration; ptr wraps from NREQ-1 to 0.
REQ-018 gnt SHALL be one-hot or zero in every cycle; ack SHALL never be high for two consecutive cycles.
REQ-019 clr high at an edge SHALL set q to 0 unless the same edge performs the GRANT->CAPTURE load, in which case the load wins and clr is ignored.
REQ-020 Changes in req or wdata for non-granted requesters SHALL NOT affect an arbitration already in progress.

Reset
REQ-021 reset SHALL force, asynchronously: state=IDLE, gnt=0, ack=0, q=0, owner=0, ptr=0.
REQ-022 reset asserted mid-GRANT or mid-CAPTURE SHALL abandon the transaction; the first arbitration after release starts from requester 0.

Configuration
REQ-023 Macro REG_SHARE_PARITY_EN defined: add output q_par (1 bit), the even parity of q, registered with q and reset to 0; it tracks clr and loads.
REQ-024 REG_SHARE_PARITY_EN undefined: q_par SHALL NOT exist and there is no parity logic.

Structure
REQ-025 Package reg_share_pkg SHALL hold the state enum (IDLE/GRANT/CAPTURE) and the default NREQ/WIDTH constants.
REQ-026 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs one-hot and index), instantiated once.

Verification
REQ-027 Reset, then req=4'b0001 and wdata slice0=8'hA5 held -> gnt=0001 at cycle 1, q=8'hA5 and ack=1 at cycle 2, owner=0, IDLE at cycle 3.
REQ-028 req=4'b1111 held continuously -> grant order 0,1,2,3,0; ack every 3 cycles; no requester is skipped.
REQ-029 req[2] alone, dropped during GRANT -> no ack, q unchanged, next arbitration with req=4'b0100 again grants 2.
REQ-030 clr=1 on the same edge as the capture of 8'h3C -> q=8'h3C; clr=1 in IDLE -> q=0.
REQ-031 reset asserted in CAPTURE with ptr=3 -> all outputs 0 immediately; then req=4'b1001 -> grant 0.
REQ-032 With REG_SHARE_PARITY_EN, write 8'h07 -> q_par=1; then write 8'h03 -> q_par=0.
